card_slot_locator: RTL and testbench

Upstream stage of the card pixel-memory lookup on the VGA path. Tracks the raster position against a fixed grid of card slots and holds a writable slot table of card codes. For every active pixel, presents the card code and the in-card pixel coordinates to the card pixel ROM stage. Emits a hit flag delayed to line up with the ROM's one-cycle read data, so the display mux knows when to use the card pixel and when to use the background.

---
 rtl/card_slot_locator_pkg.sv | 46 ++++
 rtl/card_slot_table.sv | 33 +++
 rtl/card_slot_locator.sv | 150 +++++++++++++++
 tb/tb_card_slot_locator.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/card_slot_locator_pkg.sv
// Shared display package: card geometry, card-code ranges, visible-area limits
// and the resync state codes used by the card slot locator.
package card_slot_locator_pkg;

   localparam int CARD_W = 32;
   localparam int CARD_H = 46;
   localparam logic [5:0] EMPTY = 6'd63;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;

   // Four number colours of 13 codes each, then the two face cards.
   localparam int CODES_PER_COLOR = 13;
   localparam logic [5:0] COLOR0_FIRST = 6'd0;
   localparam logic [5:0] COLOR1_FIRST = 6'd13;
   localparam logic [5:0] COLOR2_FIRST = 6'd26;
   localparam logic [5:0] COLOR3_FIRST = 6'd39;
   localparam logic [5:0] FACE_FIRST   = 6'd52;
   localparam logic [5:0] FACE_LAST    = 6'd53;

   localparam logic ST_SYNC = 1'b0;
   localparam logic ST_RUN  = 1'b1;

   typedef enum logic [2:0] {
      CLASS_COLOR0,
      CLASS_COLOR1,
      CLASS_COLOR2,
      CLASS_COLOR3,
      CLASS_FACE,
      CLASS_EMPTY,
      CLASS_INVALID
   } card_class_t;

   function automatic card_class_t card_class(input logic [5:0] code);
      card_class_t cls;
      if (code < COLOR1_FIRST)       cls = CLASS_COLOR0;
      else if (code < COLOR2_FIRST)  cls = CLASS_COLOR1;
      else if (code < COLOR3_FIRST)  cls = CLASS_COLOR2;
      else if (code < FACE_FIRST)    cls = CLASS_COLOR3;
      else if (code <= FACE_LAST)    cls = CLASS_FACE;
      else if (code == EMPTY)        cls = CLASS_EMPTY;
      else                           cls = CLASS_INVALID;
      return cls;
   endfunction

endpackage

// File: rtl/card_slot_table.sv
// Slot table of card codes: synchronous write port, asynchronous read port.
// Out-of-range writes are dropped and out-of-range reads return EMPTY.
module card_slot_table
   import card_slot_locator_pkg::*;
#(
   parameter int ENTRIES = 52
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_en,
   input  logic [5:0] wr_slot,
   input  logic [5:0] wr_type,
   input  logic [5:0] rd_slot,
   output logic [5:0] rd_type
);

   localparam logic [6:0] LIMIT = 7'(ENTRIES);

   logic [5:0] mem [ENTRIES];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            mem[i] <= EMPTY;
         end
      end else if (wr_en && ({1'b0, wr_slot} < LIMIT)) begin
         mem[wr_slot] <= wr_type;
      end
   end

   assign rd_type = ({1'b0, rd_slot} < LIMIT) ? mem[rd_slot] : EMPTY;

endmodule

// File: rtl/card_slot_locator.sv
// Tracks the raster against the card slot grid and feeds the card pixel ROM.
// Optional slot border highlight is enabled with CARD_HIGHLIGHT_EN.
module card_slot_locator
   import card_slot_locator_pkg::*;
#(
   parameter int X0    = 64,
   parameter int Y0    = 40,
   parameter int COLS  = 13,
   parameter int ROWS  = 4,
   parameter int GAP_X = 8,
   parameter int GAP_Y = 10
) (
   input  logic       clk_25MHz,
   input  logic       rst_n,
   input  logic [9:0] h_cnt,
   input  logic [9:0] v_cnt,
   input  logic       valid,
   input  logic       wr_en,
   input  logic [5:0] wr_slot,
   input  logic [5:0] wr_type,
`ifdef CARD_HIGHLIGHT_EN
   input  logic [5:0] sel_slot,
   output logic       hl_d,
`endif
   output logic [5:0] pixel_x,
   output logic [5:0] pixel_y,
   output logic [5:0] card_type,
   output logic       card_hit_d
);

   localparam int PX = CARD_W + GAP_X;
   localparam int PY = CARD_H + GAP_Y;
   localparam logic [7:0] PX_LAST = 8'(PX - 1);
   localparam logic [7:0] PY_LAST = 8'(PY - 1);
   localparam logic [5:0] COLS_L  = 6'(COLS);
   localparam logic [5:0] ROWS_L  = 6'(ROWS);
   localparam logic [9:0] X0_L    = 10'(X0);
   localparam logic [9:0] Y0_L    = 10'(Y0);

   logic       state;
   logic [5:0] col_q, row_q, col_c;
   logic [7:0] lx_q, ly_q, lx_c;
   logic       hit_c, hit_q;
   logic [5:0] slot_idx, rd_type;

   // The horizontal registers hold the previous pixel; col_c/lx_c describe the current one.
   always_comb begin
      col_c = col_q;
      lx_c  = lx_q;
      if (h_cnt == X0_L) begin
         col_c = '0;
         lx_c  = '0;
      end else if (col_q < COLS_L) begin
         if (lx_q == PX_LAST) begin
            lx_c  = '0;
            col_c = col_q + 6'd1;
         end else begin
            lx_c = lx_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk_25MHz) begin
      if (!rst_n) begin
         col_q <= COLS_L;
         lx_q  <= '0;
         row_q <= ROWS_L;
         ly_q  <= '0;
      end else begin
         col_q <= col_c;
         lx_q  <= lx_c;
         if (h_cnt == 10'd0) begin
            if (v_cnt == Y0_L) begin
               row_q <= '0;
               ly_q  <= '0;
            end else if (row_q < ROWS_L) begin
               if (ly_q == PY_LAST) begin
                  ly_q  <= '0;
                  row_q <= row_q + 6'd1;
               end else begin
                  ly_q <= ly_q + 8'd1;
               end
            end
         end
      end
   end

   assign slot_idx = 6'(row_q * COLS_L + col_c);

   assign hit_c = (state == ST_RUN) && valid && (col_c < COLS_L) && (row_q < ROWS_L) &&
                  (lx_c < 8'(CARD_W)) && (ly_q < 8'(CARD_H));

   card_slot_table #(
      .ENTRIES (ROWS * COLS)
   ) u_table (
      .clk     (clk_25MHz),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_slot (wr_slot),
      .wr_type (wr_type),
      .rd_slot (slot_idx),
      .rd_type (rd_type)
   );

   // SYNC holds every output at its miss value until the first frame origin.
   always_ff @(posedge clk_25MHz) begin
      if (!rst_n) begin
         state      <= ST_SYNC;
         pixel_x    <= '0;
         pixel_y    <= '0;
         card_type  <= EMPTY;
         hit_q      <= 1'b0;
         card_hit_d <= 1'b0;
      end else begin
         if ((state == ST_SYNC) && (h_cnt == 10'd0) && (v_cnt == 10'd0)) begin
            state <= ST_RUN;
         end
         hit_q      <= hit_c;
         card_hit_d <= hit_q;
         if (hit_c) begin
            pixel_x   <= lx_c[5:0];
            pixel_y   <= ly_q[5:0];
            card_type <= rd_type;
         end else begin
            pixel_x   <= '0;
            pixel_y   <= '0;
            card_type <= EMPTY;
         end
      end
   end

`ifdef CARD_HIGHLIGHT_EN
   logic border_c, hl_c, hl_q;

   assign border_c = (lx_c < 8'd2) || (lx_c > 8'(CARD_W - 3)) ||
                     (ly_q < 8'd2) || (ly_q > 8'(CARD_H - 3));
   assign hl_c     = hit_c && border_c && (slot_idx == sel_slot);

   always_ff @(posedge clk_25MHz) begin
      if (!rst_n) begin
         hl_q <= 1'b0;
         hl_d <= 1'b0;
      end else begin
         hl_q <= hl_c;
         hl_d <= hl_q;
      end
   end
`endif

endmodule

// File: tb/tb_card_slot_locator.sv
// Self-checking bench for card_slot_locator: drives shortened raster frames with
// random valid drops and table writes, and compares against a geometric model.
module tb_card_slot_locator;
   import card_slot_locator_pkg::*;

   localparam int X0    = 64;
   localparam int Y0    = 40;
   localparam int COLS  = 13;
   localparam int ROWS  = 4;
   localparam int GAP_X = 8;
   localparam int GAP_Y = 10;
   localparam int PX    = CARD_W + GAP_X;
   localparam int PY    = CARD_H + GAP_Y;
   localparam int SLOTS = ROWS * COLS;

   logic       clk_25MHz = 1'b0;
   logic       rst_n     = 1'b0;
   logic [9:0] h_cnt     = '0;
   logic [9:0] v_cnt     = '0;
   logic       valid     = 1'b0;
   logic       wr_en     = 1'b0;
   logic [5:0] wr_slot   = '0;
   logic [5:0] wr_type   = '0;
   logic [5:0] pixel_x, pixel_y, card_type;
   logic       card_hit_d;
`ifdef CARD_HIGHLIGHT_EN
   logic [5:0] sel_slot = '0;
   logic       hl_d;
   logic       hl_p1 = 1'b0;
`endif

   int   vectors     = 0;
   int   miscompares = 0;
   logic [5:0] tbl [SLOTS];
   bit   running     = 0;
   logic hit_p1      = 1'b0;
   bit   slot3_test  = 0;

   always #20 clk_25MHz = ~clk_25MHz;

   card_slot_locator #(
      .X0    (X0),
      .Y0    (Y0),
      .COLS  (COLS),
      .ROWS  (ROWS),
      .GAP_X (GAP_X),
      .GAP_Y (GAP_Y)
   ) dut (
      .clk_25MHz  (clk_25MHz),
      .rst_n      (rst_n),
      .h_cnt      (h_cnt),
      .v_cnt      (v_cnt),
      .valid      (valid),
      .wr_en      (wr_en),
      .wr_slot    (wr_slot),
      .wr_type    (wr_type),
`ifdef CARD_HIGHLIGHT_EN
      .sel_slot   (sel_slot),
      .hl_d       (hl_d),
`endif
      .pixel_x    (pixel_x),
      .pixel_y    (pixel_y),
      .card_type  (card_type),
      .card_hit_d (card_hit_d)
   );

   // Geometry straight from screen coordinates: slot = offset / pitch, in-card = offset % pitch.
   function automatic void model_pixel(input int h, input int v, input logic vld,
                                       output logic hit, output int px, output int py,
                                       output int slot);
      int dx, dy;
      hit = 1'b0; px = 0; py = 0; slot = 0;
      if (h < X0 || v < Y0 || !vld) return;
      dx = h - X0;
      dy = v - Y0;
      if (dx / PX >= COLS || dy / PY >= ROWS) return;
      if (dx % PX >= CARD_W || dy % PY >= CARD_H) return;
      hit  = 1'b1;
      px   = dx % PX;
      py   = dy % PY;
      slot = (dy / PY) * COLS + dx / PX;
   endfunction

   task automatic step(input int h, input int v, input bit do_rst, input bit we,
                       input int ws, input int wt, input bit drop_vld);
      logic       vld, hit, exp_hd;
      int         px, py, slot;
      logic [5:0] exp_px, exp_py, exp_type;
`ifdef CARD_HIGHLIGHT_EN
      logic       hl, exp_hl;
`endif
      vld = (h < SCREEN_W) && (v < SCREEN_H) && !(drop_vld && ($urandom_range(0, 15) == 0));
      h_cnt   = 10'(h);
      v_cnt   = 10'(v);
      valid   = vld;
      rst_n   = !do_rst;
      wr_en   = we;
      wr_slot = 6'(ws);
      wr_type = 6'(wt);

      model_pixel(h, v, vld, hit, px, py, slot);
      if (!running || do_rst) hit = 1'b0;
      exp_px   = hit ? 6'(px) : 6'd0;
      exp_py   = hit ? 6'(py) : 6'd0;
      exp_type = hit ? tbl[slot] : EMPTY;
      exp_hd   = do_rst ? 1'b0 : hit_p1;
`ifdef CARD_HIGHLIGHT_EN
      hl     = hit && (slot == int'(sel_slot)) &&
               (px < 2 || px > CARD_W - 3 || py < 2 || py > CARD_H - 3);
      exp_hl = do_rst ? 1'b0 : hl_p1;
`endif

      @(posedge clk_25MHz);
      #1;

      vectors++;
      assert (pixel_x === exp_px) else begin
         miscompares++;
         $error("[TB] FAIL pixel_x h=%0d v=%0d observed %0d expected %0d", h, v, pixel_x, exp_px);
      end
      vectors++;
      assert (pixel_y === exp_py) else begin
         miscompares++;
         $error("[TB] FAIL pixel_y h=%0d v=%0d observed %0d expected %0d", h, v, pixel_y, exp_py);
      end
      vectors++;
      assert (card_type === exp_type) else begin
         miscompares++;
         $error("[TB] FAIL card_type h=%0d v=%0d observed %0d expected %0d", h, v, card_type, exp_type);
      end
      vectors++;
      assert (card_hit_d === exp_hd) else begin
         miscompares++;
         $error("[TB] FAIL card_hit_d h=%0d v=%0d observed %b expected %b", h, v, card_hit_d, exp_hd);
      end
`ifdef CARD_HIGHLIGHT_EN
      vectors++;
      assert (hl_d === exp_hl) else begin
         miscompares++;
         $error("[TB] FAIL hl_d h=%0d v=%0d observed %b expected %b", h, v, hl_d, exp_hl);
      end
      hl_p1 = hl;
`endif

      hit_p1 = hit;
      if (do_rst) begin
         for (int i = 0; i < SLOTS; i++) tbl[i] = EMPTY;
         running = 0;
      end else begin
         if (we && ws < SLOTS) tbl[ws] = 6'(wt);
         if (h == 0 && v == 0) running = 1;
      end
   endtask

   // Every line gets its h=0 cycle; selected lines also sweep the whole grid width.
   task automatic run_line(input int v, input bit full, input bit rnd_wr,
                           input bit drop_vld, input int rst_line);
      step(0, v, v == rst_line, 0, 0, 0, drop_vld);
      if (full) begin
         for (int h = X0 - 2; h <= 590; h++) begin
            bit we;
            int ws, wt;
            we = 0; ws = 0; wt = 0;
            if (rnd_wr && $urandom_range(0, 31) == 0) begin
               we = 1;
               ws = $urandom_range(0, 63);
               wt = $urandom_range(0, 63);
            end
            if (slot3_test && v == Y0 && h == X0 + 3 * PX + 5) begin
               we = 1; ws = 3; wt = 50;
            end
            step(h, v, 0, we, ws, wt, drop_vld);
         end
      end
   endtask

   task automatic run_frame(input bit rnd_wr, input bit drop_vld, input int rst_line);
      for (int v = 0; v < 270; v++) begin
         bit full;
         full = (v == 40 || v == 41 || v == 85 || v == 95 || v == 96 || v == 100 ||
                 v == 141 || v == 150 || v == 200 || v == 254) ||
                (v >= Y0 && $urandom_range(0, 15) == 0);
         run_line(v, full, rnd_wr && (rst_line < 0 || v < rst_line), drop_vld, rst_line);
      end
   endtask

   initial begin
      for (int i = 0; i < SLOTS; i++) tbl[i] = EMPTY;
      $display("[TB] start");

      step(700, 500, 1, 0, 0, 0, 0);
      step(700, 500, 1, 0, 0, 0, 0);
      step(700, 500, 0, 1, 0, 5, 0);
      step(700, 500, 0, 1, 14, 27, 0);
      step(700, 500, 0, 1, 60, 9, 0);

`ifdef CARD_HIGHLIGHT_EN
      sel_slot = 6'd1;
`endif
      slot3_test = 1;
      run_frame(0, 0, -1);
      slot3_test = 0;

      run_frame(1, 1, 100);
      run_frame(0, 1, -1);

`ifdef CARD_HIGHLIGHT_EN
      sel_slot = 6'($urandom_range(0, SLOTS - 1));
`endif
      run_frame(1, 1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
